// File: rtl/keypad_pkg.sv
// Shared keypad constants, scanner FSM states and the one-hot decode helper
// used to classify a completed scan frame.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } kp_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } onehot_t;

  // valid is set only when exactly one bit of s is high; idx is that bit's position.
  function automatic onehot_t onehot_index(input logic [KP_KEYS-1:0] s);
    onehot_t     r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (s[i]) begin
        n++;
        r.idx = 4'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous panel inputs; resets to all-ones so
// idle pulled-up lines read inactive straight out of reset.
module sync_2ff #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] stage_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_p0 <= '1;
      q        <= '1;
    end else begin
      stage_p0 <= d;
      q        <= stage_p0;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: walks a low row across the matrix, builds a
// 16-bit frame snapshot, and debounces whole frames into single-key events.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KP_COLS-1:0] col_in,
  output logic [KP_ROWS-1:0] row_out,
  output logic [3:0]         key_code,
  output logic               key_valid,
  output logic               key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS) + 1;
  localparam int ROW_W = $clog2(KP_ROWS);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(KP_ROWS - 1);
  localparam logic [KP_ROWS-1:0] ROW_ONE  = KP_ROWS'(1);

  logic [KP_COLS-1:0] col_sync;
  logic [DIV_W-1:0]   div;
  logic [ROW_W-1:0]   row;
  logic [KP_KEYS-1:0] snapshot;
  logic [KP_KEYS-1:0] frame_snap;
  logic               tick;
  logic               frame_end;
  logic               frame_empty;
  onehot_t            hit;

  kp_state_t          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [3:0]         cand, cand_n;
  logic [3:0]         code_n;
  logic               valid_n, held_n;

  sync_2ff #(.DATA_W(KP_COLS)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_in),
    .q     (col_sync)
  );

  assign tick      = (div == DIV_LAST);
  assign frame_end = tick && (row == ROW_LAST);
  assign row_out   = ~(ROW_ONE << row);

  // The last row is sampled on the same edge the frame is judged, so splice it in live.
  assign frame_snap  = {~col_sync, snapshot[KP_KEYS-KP_COLS-1:0]};
  assign frame_empty = (frame_snap == '0);
  assign hit         = onehot_index(frame_snap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      row      <= '0;
      snapshot <= '0;
    end else if (tick) begin
      div <= '0;
      row <= row + 1'b1;
      snapshot[row*KP_COLS +: KP_COLS] <= ~col_sync;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (hit.valid) begin
            cand_n  = hit.idx;
            cnt_n   = CNT_W'(1);
            state_n = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (hit.valid && hit.idx == cand) begin
            if (cnt + 1'b1 == CNT_DONE) begin
              state_n = PRESSED;
              cnt_n   = '0;
              code_n  = cand;
              valid_n = 1'b1;
              held_n  = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (frame_empty) begin
            cnt_n   = CNT_W'(1);
            state_n = DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (frame_empty) begin
            if (cnt + 1'b1 == CNT_DONE) begin
              state_n = IDLE;
              cnt_n   = '0;
              held_n  = 1'b0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-clk frames):
// directed frame table, reset-during-debounce sequence, then random frames vs a frame-level model.
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = SCAN_DIV * 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  int          errors;
  int          checks;

  keypad_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds a key set for one whole frame; returns outputs seen just after the frame-end edge.
  task automatic run_frame(input logic [15:0] k, output logic p, output logic [3:0] c,
                           output logic h);
    logic [3:0] exp_row;
    keys = k;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      exp_row = ~(4'b0001 << (((i + 1) % FRAME) / SCAN_DIV));
      check("row_out", {28'd0, row_out}, {28'd0, exp_row});
      if (i < FRAME - 1) check("key_valid_mid", {31'd0, key_valid}, 32'd0);
    end
    p = key_valid;
    c = key_code;
    h = key_held;
  endtask

  typedef struct {
    logic [15:0] keys;
    logic        pulse;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] k, input logic p, input logic [3:0] c,
                              input logic h, input int n);
    vec_t v;
    v.keys = k; v.pulse = p; v.code = c; v.held = h;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  // Frame-level reference: counts runs of matching frames since the last mode change.
  logic       m_held;
  int         m_run;
  int         m_erun;
  int         m_cand;
  logic [3:0] m_code;

  task automatic model_frame(input logic [15:0] k, output logic pulse);
    int n, idx;
    n = 0; idx = 0; pulse = 1'b0;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; idx = i; end
    if (!m_held) begin
      if (n == 1 && m_run > 0 && idx == m_cand) m_run++;
      else if (n == 1 && m_run == 0) begin m_cand = idx; m_run = 1; end
      else m_run = 0;
      if (m_run == DEB) begin
        m_held = 1'b1; pulse = 1'b1; m_code = 4'(m_cand); m_run = 0; m_erun = 0;
      end
    end else begin
      if (k == 16'h0) m_erun++; else m_erun = 0;
      if (m_erun == DEB) begin m_held = 1'b0; m_erun = 0; m_run = 0; end
    end
  endtask

  initial begin
    logic        p, h, mp;
    logic [3:0]  c;
    logic [15:0] prev, k;
    int          a, b, sel;
    errors = 0;
    checks = 0;
    keys   = 16'h0;
    rst_n  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_row_out", {28'd0, row_out}, 32'he);
    check("reset_key_code", {28'd0, key_code}, 32'd0);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_key_held", {31'd0, key_held}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    add(16'h0000, 0, 4'd0, 0, 2);
    add(16'h0200, 0, 4'd0, 0, 2);
    add(16'h0200, 1, 4'd9, 1, 1);
    add(16'h0200, 0, 4'd9, 1, 7);
    add(16'h0000, 0, 4'd9, 1, 2);
    add(16'h0000, 0, 4'd9, 0, 1);
    add(16'h0020, 0, 4'd9, 0, 1);
    add(16'h0000, 0, 4'd9, 0, 1);
    add(16'h0020, 0, 4'd9, 0, 1);
    add(16'h0000, 0, 4'd9, 0, 1);
    add(16'h0020, 0, 4'd9, 0, 2);
    add(16'h0020, 1, 4'd5, 1, 1);
    add(16'h0000, 0, 4'd5, 1, 2);
    add(16'h0000, 0, 4'd5, 0, 1);
    add(16'h8001, 0, 4'd5, 0, 2);
    add(16'h8000, 0, 4'd5, 0, 2);
    add(16'h8000, 1, 4'd15, 1, 1);
    add(16'h0000, 0, 4'd15, 1, 2);
    add(16'h0000, 0, 4'd15, 0, 1);
    add(16'h0040, 0, 4'd15, 0, 2);
    add(16'h0040, 1, 4'd6, 1, 1);
    add(16'h0000, 0, 4'd6, 1, 2);
    add(16'h0040, 0, 4'd6, 1, 1);
    add(16'h0000, 0, 4'd6, 1, 2);
    add(16'h0000, 0, 4'd6, 0, 1);

    foreach (tbl[i]) begin
      run_frame(tbl[i].keys, p, c, h);
      check($sformatf("tbl%0d_valid", i), {31'd0, p}, {31'd0, tbl[i].pulse});
      check($sformatf("tbl%0d_code", i), {28'd0, c}, {28'd0, tbl[i].code});
      check($sformatf("tbl%0d_held", i), {31'd0, h}, {31'd0, tbl[i].held});
    end

    // Reset while debouncing key 9 with two matching frames already counted.
    for (int f = 0; f < 2; f++) begin
      run_frame(16'h0200, p, c, h);
      check("pre_rst_valid", {31'd0, p}, 32'd0);
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_row_out", {28'd0, row_out}, 32'he);
    check("midrst_key_code", {28'd0, key_code}, 32'd0);
    check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_key_held", {31'd0, key_held}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(16'h0200, p, c, h);
      check("post_rst_valid", {31'd0, p}, 32'd0);
      check("post_rst_held", {31'd0, h}, 32'd0);
    end
    run_frame(16'h0200, p, c, h);
    check("post_rst_pulse", {31'd0, p}, 32'd1);
    check("post_rst_code", {28'd0, c}, 32'd9);
    for (int f = 0; f < DEB; f++) run_frame(16'h0000, p, c, h);
    check("post_rst_release", {31'd0, h}, 32'd0);

    m_held = 1'b0; m_run = 0; m_erun = 0; m_cand = 0; m_code = 4'd9;
    prev = 16'h0;
    for (int f = 0; f < 80; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) k = prev;
      else if (sel == 6) k = 16'h0;
      else if (sel < 9) k = 16'h1 << $urandom_range(0, 15);
      else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        k = (16'h1 << a) | (16'h1 << b);
      end
      prev = k;
      model_frame(k, mp);
      run_frame(k, p, c, h);
      check($sformatf("rnd%0d_valid", f), {31'd0, p}, {31'd0, mp});
      check($sformatf("rnd%0d_code", f), {28'd0, c}, {28'd0, m_code});
      check($sformatf("rnd%0d_held", f), {31'd0, h}, {31'd0, m_held});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
